game_timer_bank: RTL and testbench
==================================

Name: game_timer_bank

Overview:
- Parametrised successor to the free-running game clock.
- Keeps a prescaled game-time counter and adds NUM_CH independently programmable countdown channels (one-shot or periodic). Typical uses: alien march step, shot cooldown, respawn delay.
- Supports pause and clear so the host software can freeze and restart play.
- Sits between the system clock and the game-logic / host interface; all outputs are synchronous to clk.

Parameters:
- TIME_W, 32, width of gameTime counter.
- PRESCALE, 50000, clk cycles per game tick (1 ms at 50 MHz); must be >= 2.
- NUM_CH, 4, number of countdown channels (1..16).
- CH_W, 16, width of each channel count/reload value.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pause  in  1  level; 1 freezes prescaler, gameTime and all channels.
- clear_time  in  1  pulse; zeroes gameTime and prescaler.
- ld_en  in  1  pulse; load channel ld_ch.
- ld_ch  in  max(1,$clog2(NUM_CH))  channel index for load.
- ld_value  in  CH_W  initial/reload count in ticks; 0 cancels the channel.
- ld_periodic  in  1  1 = auto-reload on expiry, 0 = one-shot.
- gameTime  out  TIME_W  elapsed ticks since reset/clear.
- tick  out  1  one-cycle pulse per game tick.
- active  out  NUM_CH  per-channel running flag.
- expired  out  NUM_CH  per-channel one-cycle expiry pulse.
- status_clr  in  NUM_CH  write-1-to-clear for sticky flags (optional feature).
- status  out  NUM_CH  sticky expiry flags (optional feature).
- irq  out  1  OR of status (optional feature).

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0, gameTime=0, tick=0, all counts/reloads=0, active=0, expired=0, status=0, irq=0. Outputs stay held while reset is low; normal operation resumes on the first clk edge after release.
- Prescaler counts 0..PRESCALE-1 when pause=0.
  - Rising edge at which it equals PRESCALE-1: it wraps to 0 and tick is registered high for exactly one cycle.
  - pause=1: prescaler holds; no ticks are generated.
- gameTime increments by 1 on the cycle tick is high, modulo 2^TIME_W. Wrap from all-ones to 0 is silent.
- clear_time:
  - On the next edge, prescaler=0 and gameTime=0.
  - Overrides any increment and any tick in that cycle; no tick pulse is emitted on the clear edge.
  - Channels are unaffected.
- Channel load (ld_en=1, ld_ch < NUM_CH):
  - ld_value != 0: next edge sets count=ld_value, reload=ld_value, periodic=ld_periodic, active=1.
  - ld_value = 0: next edge sets active=0; no expiry pulse.
  - ld_ch >= NUM_CH: ignored.
  - Loads are accepted while paused.
- Channel decrement: on each cycle tick=1, every active channel not being loaded that cycle decrements.
  - If count==1 at that tick: expired[i] is registered high the following cycle (one-cycle pulse).
    - periodic=1: count=reload, active stays 1.
    - periodic=0: count=0, active=0.
- Expiry period: a channel loaded with N expires on the Nth tick after the load edge.
- Simultaneous load and tick on the same channel: load wins; no decrement, no expiry.
- Simultaneous clear_time and tick: clear wins; channels do not decrement.
- Multiple channels may expire on the same tick; all their expired bits pulse together.

Optional Feature:
- Macro: GAME_TIMER_STICKY_EN.
- Defined:
  - status[i] sets when expired[i] pulses.
  - status[i] clears on the edge where status_clr[i]=1.
  - Set wins over a same-cycle clear.
  - irq = |status, registered.
- Not defined: status and irq are tied to 0; status_clr is ignored. Port list is unchanged.

Test Plan (PRESCALE=4, NUM_CH=4, CH_W=8, TIME_W=8):
- Release reset, run 40 cycles -> tick pulses every 4 cycles; gameTime reaches 10; active=0, expired=0.
- Load ch0 value 3 one-shot -> expired[0] pulses once after the 3rd tick; active[0] falls at the same edge; no further pulses.
- Load ch2 value 2 periodic, run 10 ticks -> expired[2] pulses on ticks 2,4,6,8,10; active[2] stays 1. Then load value 0 -> active[2]=0, no pulse.
- pause=1 for 20 cycles mid-count -> gameTime, prescaler and channel counts frozen. After pause=0, the remaining delay completes exactly.
- gameTime preloaded to 255 by running 1020 cycles -> next tick wraps it to 0. clear_time on a tick cycle -> gameTime=0, no tick pulse; ch1 load on a tick cycle -> no decrement.
- Assert reset low mid-count with ch0 active -> all outputs 0 immediately, without waiting for a clk edge. With GAME_TIMER_STICKY_EN: expiry sets status and irq, status_clr=4'b0001 clears them, and set wins over a same-cycle clear.

Source files
------------

// File: rtl/game_timer_bank.sv
// game_timer_bank
//   Prescaled game-time counter plus NUM_CH programmable countdown channels
//   (one-shot or periodic).
//   Optional sticky status/irq: define GAME_TIMER_STICKY_EN.
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   pause               level, freezes prescaler, gameTime and all channels
//   clear_time          pulse, zeroes gameTime and prescaler (channels untouched)
//   ld_en/ld_ch/ld_value/ld_periodic
//                       channel load; ld_value==0 cancels the channel
//   gameTime            elapsed game ticks
//   tick                one-cycle pulse per game tick
//   active/expired      per-channel running flag / one-cycle expiry pulse
//   status_clr/status/irq
//                       sticky expiry flags, W1C, OR'd irq (optional)

module game_timer_ch #(
  parameter int CH_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [CH_W-1:0] ld_value,
  input  logic            ld_periodic,
  input  logic            dec_en,
  output logic            active,
  output logic            expired,
  output logic            fire
);
  logic [CH_W-1:0] count, reload;
  logic            periodic;

  // Expiry condition on this edge; a load on the same edge takes precedence.
  assign fire = !load && dec_en && active && (count == CH_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      reload   <= '0;
      periodic <= 1'b0;
      active   <= 1'b0;
      expired  <= 1'b0;
    end else begin
      expired <= fire;
      if (load) begin
        if (ld_value != '0) begin
          count    <= ld_value;
          reload   <= ld_value;
          periodic <= ld_periodic;
          active   <= 1'b1;
        end else begin
          count  <= '0;
          active <= 1'b0;
        end
      end else if (dec_en && active) begin
        if (count == CH_W'(1)) begin
          if (periodic) begin
            count <= reload;
          end else begin
            count  <= '0;
            active <= 1'b0;
          end
        end else begin
          count <= count - CH_W'(1);
        end
      end
    end
  end
endmodule

module game_timer_bank #(
  parameter int TIME_W   = 32,
  parameter int PRESCALE = 50000,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 16,
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic              clear_time,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_ch,
  input  logic [CH_W-1:0]   ld_value,
  input  logic              ld_periodic,
  output logic [TIME_W-1:0] gameTime,
  output logic              tick,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] expired,
  input  logic [NUM_CH-1:0] status_clr,
  output logic [NUM_CH-1:0] status,
  output logic              irq
);
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0]     presc;
  logic [NUM_CH-1:0] fire;
  logic              dec_en;

  // Channels advance on the registered tick; clear and pause both suppress it.
  assign dec_en = tick && !pause && !clear_time;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc    <= '0;
      gameTime <= '0;
      tick     <= 1'b0;
    end else if (clear_time) begin
      presc    <= '0;
      gameTime <= '0;
      tick     <= 1'b0;
    end else if (pause) begin
      tick <= 1'b0;
    end else begin
      gameTime <= gameTime + TIME_W'(tick);
      if (presc == PW'(PRESCALE - 1)) begin
        presc <= '0;
        tick  <= 1'b1;
      end else begin
        presc <= presc + PW'(1);
        tick  <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    game_timer_ch #(.CH_W(CH_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .load       (ld_en && (ld_ch == IDX_W'(i))),
      .ld_value   (ld_value),
      .ld_periodic(ld_periodic),
      .dec_en     (dec_en),
      .active     (active[i]),
      .expired    (expired[i]),
      .fire       (fire[i])
    );
  end

`ifdef GAME_TIMER_STICKY_EN
  logic [NUM_CH-1:0] status_nxt;
  // A new expiry wins over a same-cycle clear.
  assign status_nxt = (status & ~status_clr) | fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status <= '0;
      irq    <= 1'b0;
    end else begin
      status <= status_nxt;
      irq    <= |status_nxt;
    end
  end
`else
  logic unused_sticky;
  assign unused_sticky = ^{status_clr, fire};
  assign status = '0;
  assign irq    = 1'b0;
`endif
endmodule

// File: tb/tb_game_timer_bank.sv
module tb_game_timer_bank;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pause = 1'b0;
  logic       clear_time = 1'b0;
  logic       ld_en = 1'b0;
  logic [1:0] ld_ch = '0;
  logic [7:0] ld_value = '0;
  logic       ld_periodic = 1'b0;
  logic [3:0] status_clr = '0;
  logic [7:0] gameTime;
  logic       tick;
  logic [3:0] active, expired, status;
  logic       irq;

  game_timer_bank #(.TIME_W(8), .PRESCALE(4), .NUM_CH(4), .CH_W(8)) dut (
    .clk(clk), .reset(reset), .pause(pause), .clear_time(clear_time),
    .ld_en(ld_en), .ld_ch(ld_ch), .ld_value(ld_value), .ld_periodic(ld_periodic),
    .gameTime(gameTime), .tick(tick), .active(active), .expired(expired),
    .status_clr(status_clr), .status(status), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       ld;
    logic [1:0] ch;
    logic [7:0] val;
    logic       per;
    logic       pse;
    logic       clr;
    int         n;
    logic [7:0] gt;
    logic       tk;
    logic [3:0] act;
    logic [3:0] exp;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(int ld, int ch, int val, int per, int pse, int clr,
                              int n, int gt, int tk, int act, int exp);
    vec_t r;
    r.ld = 1'(ld); r.ch = 2'(ch); r.val = 8'(val); r.per = 1'(per);
    r.pse = 1'(pse); r.clr = 1'(clr); r.n = n; r.gt = 8'(gt); r.tk = 1'(tk);
    r.act = 4'(act); r.exp = 4'(exp);
    return r;
  endfunction

  initial begin
    //          ld ch val per pse clr    n   gt tk  act     exp
    v.push_back(mk(0, 0, 0, 0, 0, 0,   40,   9, 1, 4'h0, 4'h0)); // 10th tick
    v.push_back(mk(0, 0, 0, 0, 0, 0,    1,  10, 0, 4'h0, 4'h0));
    v.push_back(mk(1, 0, 3, 0, 0, 0,    1,  10, 0, 4'h1, 4'h0)); // ch0 one-shot 3
    v.push_back(mk(0, 0, 0, 0, 0, 0,   10,  12, 1, 4'h1, 4'h0));
    v.push_back(mk(0, 0, 0, 0, 0, 0,    1,  13, 0, 4'h0, 4'h1)); // expiry
    v.push_back(mk(0, 0, 0, 0, 0, 0,    1,  13, 0, 4'h0, 4'h0));
    v.push_back(mk(0, 0, 0, 0, 0, 0,   20,  18, 0, 4'h0, 4'h0));
    v.push_back(mk(1, 2, 2, 1, 0, 0,    1,  18, 0, 4'h4, 4'h0)); // ch2 periodic 2
    v.push_back(mk(0, 0, 0, 0, 0, 0,    6,  20, 0, 4'h4, 4'h4));
    v.push_back(mk(0, 0, 0, 0, 0, 0,    8,  22, 0, 4'h4, 4'h4));
    v.push_back(mk(0, 0, 0, 0, 0, 0,    8,  24, 0, 4'h4, 4'h4));
    v.push_back(mk(0, 0, 0, 0, 0, 0,    8,  26, 0, 4'h4, 4'h4));
    v.push_back(mk(0, 0, 0, 0, 0, 0,    8,  28, 0, 4'h4, 4'h4));
    v.push_back(mk(0, 0, 0, 0, 0, 0,    1,  28, 0, 4'h4, 4'h0));
    v.push_back(mk(1, 2, 0, 0, 0, 0,    1,  28, 0, 4'h0, 4'h0)); // cancel ch2
    v.push_back(mk(0, 0, 0, 0, 0, 0,   10,  31, 0, 4'h0, 4'h0));
    v.push_back(mk(1, 1, 2, 0, 0, 0,    1,  31, 0, 4'h2, 4'h0)); // ch1 one-shot 2
    v.push_back(mk(0, 0, 0, 0, 0, 0,    4,  32, 0, 4'h2, 4'h0));
    v.push_back(mk(0, 0, 0, 0, 1, 0,   20,  32, 0, 4'h2, 4'h0)); // paused
    v.push_back(mk(0, 0, 0, 0, 0, 0,    2,  32, 1, 4'h2, 4'h0));
    v.push_back(mk(0, 0, 0, 0, 0, 0,    1,  33, 0, 4'h0, 4'h2));
    v.push_back(mk(0, 0, 0, 0, 0, 1,    1,   0, 0, 4'h0, 4'h0)); // clear
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1021, 255, 0, 4'h0, 4'h0));
    v.push_back(mk(0, 0, 0, 0, 0, 0,    3, 255, 1, 4'h0, 4'h0));
    v.push_back(mk(0, 0, 0, 0, 0, 0,    1,   0, 0, 4'h0, 4'h0)); // wrap
    v.push_back(mk(0, 0, 0, 0, 0, 0,    2,   0, 0, 4'h0, 4'h0));
    v.push_back(mk(0, 0, 0, 0, 0, 1,    1,   0, 0, 4'h0, 4'h0)); // clear kills tick
    v.push_back(mk(1, 3, 1, 0, 0, 0,    4,   0, 1, 4'h8, 4'h0));
    v.push_back(mk(0, 0, 0, 0, 0, 1,    1,   0, 0, 4'h8, 4'h0)); // clear+tick: no dec
    v.push_back(mk(0, 0, 0, 0, 0, 0,    4,   0, 1, 4'h8, 4'h0));
    v.push_back(mk(0, 0, 0, 0, 0, 0,    1,   1, 0, 4'h0, 4'h8));
    v.push_back(mk(1, 1, 1, 0, 0, 0,    3,   1, 1, 4'h2, 4'h0));
    v.push_back(mk(1, 1, 2, 0, 0, 0,    1,   2, 0, 4'h2, 4'h0)); // load beats tick
    v.push_back(mk(0, 0, 0, 0, 0, 0,    7,   3, 1, 4'h2, 4'h0));
    v.push_back(mk(0, 0, 0, 0, 0, 0,    1,   4, 0, 4'h0, 4'h2));
    v.push_back(mk(1, 0, 2, 0, 0, 0,    1,   4, 0, 4'h1, 4'h0));
    v.push_back(mk(1, 1, 2, 0, 0, 0,    7,   6, 0, 4'h0, 4'h3)); // joint expiry

    // reset state
    step(3);
    check("rst_gt", 32'(gameTime), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_active", 32'(active), 0);
    check("rst_expired", 32'(expired), 0);
    check("rst_status", 32'({irq, status}), 0);
    reset = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      ld_en = v[i].ld; ld_ch = v[i].ch; ld_value = v[i].val; ld_periodic = v[i].per;
      pause = v[i].pse; clear_time = v[i].clr;
      step(1);
      ld_en = 1'b0; clear_time = 1'b0;
      if (v[i].n > 1) step(v[i].n - 1);
      check($sformatf("v%0d_gt", i), 32'(gameTime), 32'(v[i].gt));
      check($sformatf("v%0d_tick", i), 32'(tick), 32'(v[i].tk));
      check($sformatf("v%0d_active", i), 32'(active), 32'(v[i].act));
      check($sformatf("v%0d_expired", i), 32'(expired), 32'(v[i].exp));
`ifndef GAME_TIMER_STICKY_EN
      check($sformatf("v%0d_status", i), 32'({irq, status}), 0);
`endif
    end

    // asynchronous reset mid-count
    ld_en = 1'b1; ld_ch = 2'd0; ld_value = 8'd5; ld_periodic = 1'b0;
    step(1);
    ld_en = 1'b0;
    check("pre_rst_active", 32'(active), 32'h1);
    reset = 1'b0;
    #2;
    check("async_rst_gt", 32'(gameTime), 0);
    check("async_rst_active", 32'(active), 0);
    check("async_rst_tick_exp", 32'({tick, expired}), 0);
    check("async_rst_status", 32'({irq, status}), 0);
    step(2);
    check("held_rst_gt", 32'(gameTime), 0);
    check("held_rst_active", 32'(active), 0);
    reset = 1'b1;

`ifdef GAME_TIMER_STICKY_EN
    ld_en = 1'b1; ld_ch = 2'd0; ld_value = 8'd1;
    step(1);
    ld_en = 1'b0;
    step(4);
    check("sticky_exp", 32'(expired), 32'h1);
    check("sticky_set", 32'(status), 32'h1);
    check("sticky_irq", 32'(irq), 1);
    step(2);
    check("sticky_hold", 32'({irq, status}), 32'h11);
    status_clr = 4'b0001;
    step(1);
    status_clr = 4'b0000;
    check("sticky_clr", 32'({irq, status}), 0);
    ld_en = 1'b1;
    step(1);
    ld_en = 1'b0;
    step(3);
    check("sticky_pre", 32'({irq, status}), 0);
    status_clr = 4'b0001;
    step(1);
    status_clr = 4'b0000;
    check("sticky_set_wins", 32'({irq, status}), 32'h11);
    step(1);
    check("sticky_after", 32'({irq, status}), 32'h11);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
